// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared FSM state type and default sizing for the round-robin burst arbiter
package mux_rr_arbiter_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin search for the first set request at or above ptr, wrapping
//   req     in  [N_REQ]    request vector
//   ptr     in  [IW]       search start index (0..N_REQ-1)
//   winner  out [IW]       first requesting index found
//   any_req out            at least one request present
module rr_priority_picker
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    winner,
    output logic             any_req
);
    logic [IW-1:0] idx;
    // Walk offsets from farthest to nearest so the closest requester to ptr is written last and wins.
    always_comb begin
        winner = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (req[idx]) winner = idx;
        end
        any_req = |req;
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin burst arbiter muxing N_REQ valid/ready streams onto one output
//   clk, rst                      clock, async active-high reset
//   req_vld/req_data/req_last     per-requester stream in (data packed WIDTH per lane)
//   req_rdy                       per-requester ready (only the granted lane follows out_rdy)
//   out_vld/out_data/out_last     shared output stream, out_rdy downstream ready
//   grant_idx, busy               current grant and burst-in-progress flag
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_vld,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_rdy,
    output logic                     out_vld,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    input  logic                     out_rdy,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     busy
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
    state_t state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, winner;
    logic any_req, sel_last;
    logic [WIDTH-1:0] lanes [N_REQ];
    rr_priority_picker #(.N_REQ(N_REQ)) u_pick (
        .req(req_vld),
        .ptr(ptr_q),
        .winner(winner),
        .any_req(any_req)
    );
    // Pure combinational path from the granted lane; nothing on the data path is registered.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) lanes[i] = req_data[i*WIDTH +: WIDTH];
        busy = state_q == BURST;
        sel_last = req_last[grant_q];
        out_vld = busy & req_vld[grant_q];
        out_last = busy & sel_last;
        out_data = lanes[grant_q];
        req_rdy = busy ? N_REQ'(out_rdy) << grant_q : '0;
        state_d = state_q;
        ptr_d = ptr_q;
        grant_d = grant_q;
        if (!busy && any_req) begin
            state_d = BURST;
            grant_d = winner;
        end
        if (out_vld && out_rdy && sel_last) begin
            state_d = IDLE;
            ptr_d = grant_q == LAST_IDX ? '0 : grant_q + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            grant_q <= grant_d;
        end
    end
    assign grant_idx = grant_q;
endmodule
